// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, icache request, next-PC redirects and the IF/ID latch.
// Optional fetch/stall statistics counters are enabled by defining FETCH_STATS_EN.
module fetch_stage #(
    parameter logic [31:0] PC_INIT  = 32'h00000000,
    parameter logic [31:0] NOP_WORD = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    output logic [31:0] Instruction,
    output logic [31:0] PC4,
    output logic        if_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    logic [31:0] pc_reg, pc_next;
    logic [31:0] pend_addr_reg, pend_addr_next;
    logic        pend_v_reg, pend_v_next;
    logic        halted_reg, halted_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pc4_reg, pc4_next;
    logic        valid_reg, valid_next;

    logic        redirect;
    logic        halting;
    logic        flush;
    logic        load_valid;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign imemaddr    = pc_reg;
    assign imemREN     = ~halted_reg;
    assign Instruction = instr_reg;
    assign PC4         = pc4_reg;
    assign if_valid    = valid_reg;

    always_comb begin
        target = branch_addr;
        case (pc_sel)
            2'b01:   target = branch_addr;
            2'b10:   target = jump_addr;
            2'b11:   target = jr_addr;
            default: target = branch_addr;
        endcase
    end

    // The halt input blocks this cycle's PC advance and IF/ID load; imemREN drops a cycle later.
    assign redirect   = (pc_sel != 2'b00);
    assign halting    = halted_reg | halt;
    assign flush      = redirect | pend_v_reg;
    assign pc_plus4   = pc_reg + 32'd4;
    assign load_valid = ~flush & ~stall & ihit & ~halting;

    always_comb begin
        halted_next    = halting;
        pc_next        = pc_reg;
        pend_addr_next = pend_addr_reg;
        pend_v_next    = pend_v_reg;

        // Capture every redirect; it is consumed right away unless stalled or halted.
        if (redirect) begin
            pend_addr_next = target;
            pend_v_next    = 1'b1;
        end

        if (!halting && !stall) begin
            if (redirect) begin
                pc_next     = target;
                pend_v_next = 1'b0;
            end else if (pend_v_reg) begin
                pc_next     = pend_addr_reg;
                pend_v_next = 1'b0;
            end else if (ihit) begin
                pc_next = pc_plus4;
            end
        end
    end

    always_comb begin
        instr_next = instr_reg;
        pc4_next   = pc4_reg;
        valid_next = valid_reg;

        if (flush) begin
            instr_next = NOP_WORD;
            pc4_next   = 32'd0;
            valid_next = 1'b0;
        end else if (stall) begin
            instr_next = instr_reg;
            pc4_next   = pc4_reg;
            valid_next = valid_reg;
        end else if (load_valid) begin
            instr_next = imemload;
            pc4_next   = pc_plus4;
            valid_next = 1'b1;
        end else begin
            // Bubble: PC4 keeps its last value; only the instruction and valid bit are cleared.
            instr_next = NOP_WORD;
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_reg        <= PC_INIT;
            pend_addr_reg <= 32'd0;
            pend_v_reg    <= 1'b0;
            halted_reg    <= 1'b0;
            instr_reg     <= NOP_WORD;
            pc4_reg       <= 32'd0;
            valid_reg     <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            pend_addr_reg <= pend_addr_next;
            pend_v_reg    <= pend_v_next;
            halted_reg    <= halted_next;
            instr_reg     <= instr_next;
            pc4_reg       <= pc4_next;
            valid_reg     <= valid_next;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_reg, fetch_count_next;
    logic [31:0] stall_count_reg, stall_count_next;

    assign fetch_count = fetch_count_reg;
    assign stall_count = stall_count_reg;

    always_comb begin
        fetch_count_next = fetch_count_reg;
        stall_count_next = stall_count_reg;
        if (load_valid)
            fetch_count_next = fetch_count_reg + 32'd1;
        if (!halted_reg && (!ihit || stall))
            stall_count_next = stall_count_reg + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_count_reg <= 32'd0;
            stall_count_reg <= 32'd0;
        end else begin
            fetch_count_reg <= fetch_count_next;
            stall_count_reg <= stall_count_next;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID and PC values queued per cycle, popped after each edge.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] branch_addr, jump_addr, jr_addr;
    logic        halt;
    logic [31:0] Instruction, PC4;
    logic        if_valid;

    // Second instance used for the PC wrap-around scenario.
    logic        w_nrst, w_ihit, w_stall, w_halt;
    logic [31:0] w_load, w_zero;
    logic [1:0]  w_sel;
    logic        w_ren, w_valid;
    logic [31:0] w_addr, w_instr, w_pc4;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count, w_fetch_count, w_stall_count;
`endif

    always #5 CLK = ~CLK;

    fetch_stage #(.PC_INIT(32'h00000000), .NOP_WORD(32'h00000000)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .pc_sel(pc_sel),
        .branch_addr(branch_addr), .jump_addr(jump_addr), .jr_addr(jr_addr),
        .halt(halt), .Instruction(Instruction), .PC4(PC4), .if_valid(if_valid)
`ifdef FETCH_STATS_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_stage #(.PC_INIT(32'hFFFFFFF8), .NOP_WORD(32'h00000000)) dut_w (
        .CLK(CLK), .nRST(w_nrst), .ihit(w_ihit), .imemload(w_load),
        .imemREN(w_ren), .imemaddr(w_addr), .stall(w_stall), .pc_sel(w_sel),
        .branch_addr(w_zero), .jump_addr(w_zero), .jr_addr(w_zero),
        .halt(w_halt), .Instruction(w_instr), .PC4(w_pc4), .if_valid(w_valid)
`ifdef FETCH_STATS_EN
        , .fetch_count(w_fetch_count), .stall_count(w_stall_count)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        ren;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        else
            passed++;
    endtask

    // Drive one cycle of stimulus, queue what IF/ID and the PC must look like after the edge.
    task automatic step(input string tag, input logic i_hit, input logic [31:0] load,
                        input logic i_stall, input logic [1:0] sel, input logic [31:0] tgt,
                        input logic i_halt, input logic [31:0] e_addr, input logic e_valid,
                        input logic [31:0] e_instr, input logic [31:0] e_pc4, input logic e_ren);
        exp_t e;
        exp_t got;
        ihit        = i_hit;
        imemload    = load;
        stall       = i_stall;
        pc_sel      = sel;
        halt        = i_halt;
        branch_addr = (sel == 2'b01) ? tgt : 32'h0BAD0000;
        jump_addr   = (sel == 2'b10) ? tgt : 32'h0BAD1000;
        jr_addr     = (sel == 2'b11) ? tgt : 32'h0BAD2000;
        e.tag = tag; e.addr = e_addr; e.valid = e_valid;
        e.instr = e_instr; e.pc4 = e_pc4; e.ren = e_ren;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        got = sb_q.pop_front();
        check_val({got.tag, ".addr"}, imemaddr, got.addr);
        check_val({got.tag, ".valid"}, {31'd0, if_valid}, {31'd0, got.valid});
        check_val({got.tag, ".instr"}, Instruction, got.instr);
        check_val({got.tag, ".pc4"}, PC4, got.pc4);
        check_val({got.tag, ".ren"}, {31'd0, imemREN}, {31'd0, got.ren});
        $display("cycle %-10s addr=%h valid=%b instr=%h pc4=%h ren=%b",
                 got.tag, imemaddr, if_valid, Instruction, PC4, imemREN);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] I1 = 32'h20010005, I2 = 32'h20020006, I3 = 32'h20030007;
    localparam logic [31:0] I4 = 32'h20040008, I5 = 32'h8C050000, I6 = 32'hAC060004;
    localparam logic [31:0] I7 = 32'h00A63820, I8 = 32'h1000FFFF, I9 = 32'h3C0A1234;

    initial begin
        logic [31:0] w_exp_addr[$];
        logic [31:0] w_exp_pc4[$];
        nRST = 1'b0; ihit = 1'b0; imemload = 32'd0; stall = 1'b0; pc_sel = 2'b00;
        branch_addr = 32'd0; jump_addr = 32'd0; jr_addr = 32'd0; halt = 1'b0;
        w_nrst = 1'b0; w_ihit = 1'b0; w_stall = 1'b0; w_halt = 1'b0;
        w_load = 32'd0; w_zero = 32'd0; w_sel = 2'b00;

        #1;
        check_val("rst.addr", imemaddr, 32'h0);
        check_val("rst.ren", {31'd0, imemREN}, 32'd1);
        check_val("rst.valid", {31'd0, if_valid}, 32'd0);
        check_val("rst.instr", Instruction, 32'h0);
        check_val("rst.pc4", PC4, 32'h0);
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;

        //    tag         hit  load  stl  sel    tgt          hlt  e_addr        ev  e_instr e_pc4         ren
        step("line0",     1, I1,   0, 2'b00, 32'h0,        0, 32'h4,        1, I1,  32'h4,        1);
        step("line1",     1, I2,   0, 2'b00, 32'h0,        0, 32'h8,        1, I2,  32'h8,        1);
        step("miss0",     0, I3,   0, 2'b00, 32'h0,        0, 32'h8,        0, 32'h0, 32'h8,      1);
        step("miss1",     0, I3,   0, 2'b00, 32'h0,        0, 32'h8,        0, 32'h0, 32'h8,      1);
        step("miss2",     0, I3,   0, 2'b00, 32'h0,        0, 32'h8,        0, 32'h0, 32'h8,      1);
        step("hit8",      1, I3,   0, 2'b00, 32'h0,        0, 32'hC,        1, I3,  32'hC,        1);
        step("hitC",      1, I4,   0, 2'b00, 32'h0,        0, 32'h10,       1, I4,  32'h10,       1);
        step("jmpmiss",   0, I4,   0, 2'b10, 32'h400,      0, 32'h400,      0, 32'h0, 32'h0,      1);
        step("hit400",    1, I5,   0, 2'b00, 32'h0,        0, 32'h404,      1, I5,  32'h404,      1);
        step("stlbr0",    1, I6,   1, 2'b01, 32'h80,       0, 32'h404,      0, 32'h0, 32'h0,      1);
        step("stlbr1",    1, I6,   1, 2'b00, 32'h0,        0, 32'h404,      0, 32'h0, 32'h0,      1);
        step("pendapp",   1, I6,   0, 2'b00, 32'h0,        0, 32'h80,       0, 32'h0, 32'h0,      1);
        step("hit80",     1, I6,   0, 2'b00, 32'h0,        0, 32'h84,       1, I6,  32'h84,       1);
        step("stlhold",   1, I7,   1, 2'b00, 32'h0,        0, 32'h84,       1, I6,  32'h84,       1);
        step("hit84",     1, I7,   0, 2'b00, 32'h0,        0, 32'h88,       1, I7,  32'h88,       1);
        step("ovwr0",     1, I7,   1, 2'b01, 32'h200,      0, 32'h88,       0, 32'h0, 32'h0,      1);
        step("ovwr1",     1, I7,   1, 2'b10, 32'h300,      0, 32'h88,       0, 32'h0, 32'h0,      1);
        step("ovwrapp",   1, I7,   0, 2'b00, 32'h0,        0, 32'h300,      0, 32'h0, 32'h0,      1);
        step("jr24",      1, I7,   0, 2'b11, 32'h24,       0, 32'h24,       0, 32'h0, 32'h0,      1);
        step("halt",      1, I8,   0, 2'b00, 32'h0,        1, 32'h24,       0, 32'h0, 32'h0,      0);
        step("halted1",   1, I8,   0, 2'b00, 32'h0,        0, 32'h24,       0, 32'h0, 32'h0,      0);
        step("haltjr",    1, I8,   0, 2'b11, 32'h100,      0, 32'h24,       0, 32'h0, 32'h0,      0);
        step("halted2",   1, I8,   0, 2'b00, 32'h0,        0, 32'h24,       0, 32'h0, 32'h0,      0);

        // Asynchronous reset in the middle of a miss cycle.
        ihit = 1'b0; pc_sel = 2'b00;
        #3 nRST = 1'b0;
        #1;
        check_val("arst.addr", imemaddr, 32'h0);
        check_val("arst.ren", {31'd0, imemREN}, 32'd1);
        check_val("arst.valid", {31'd0, if_valid}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        step("postrst",   1, I9,   0, 2'b00, 32'h0,        0, 32'h4,        1, I9,  32'h4,        1);

        // Wrap-around instance: PC walks FFFFFFF8 -> FFFFFFFC -> 0 -> 4.
        w_ihit = 1'b1; w_load = I1;
        @(negedge CLK);
        w_nrst = 1'b1;
        #1;
        check_val("wrap.init", w_addr, 32'hFFFFFFF8);
        w_exp_addr.push_back(32'hFFFFFFFC); w_exp_pc4.push_back(32'hFFFFFFFC);
        w_exp_addr.push_back(32'h00000000); w_exp_pc4.push_back(32'h00000000);
        w_exp_addr.push_back(32'h00000004); w_exp_pc4.push_back(32'h00000004);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ea, ep;
            @(posedge CLK);
            #1;
            ea = w_exp_addr.pop_front();
            ep = w_exp_pc4.pop_front();
            check_val("wrap.addr", w_addr, ea);
            check_val("wrap.pc4", w_pc4, ep);
            check_val("wrap.valid", {31'd0, w_valid}, 32'd1);
            $display("wrap %0d addr=%h pc4=%h valid=%b", i, w_addr, w_pc4, w_valid);
        end
`ifdef FETCH_STATS_EN
        check_val("stats.fetch3", w_fetch_count, 32'd3);
        check_val("stats.stall0", w_stall_count, 32'd0);
`endif
        w_ihit = 1'b0;
        @(posedge CLK);
        #1;
        check_val("wrap.misshold", w_addr, 32'h4);
`ifdef FETCH_STATS_EN
        check_val("stats.fetchhold", w_fetch_count, 32'd3);
        check_val("stats.stall1", w_stall_count, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
